// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control FSM.
// MC_CTRL_JALR_EN adds the JALRADR state and JALR opcode support.
package mc_ctrl_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECR    = 4'd6;
    localparam state_t S_EXECI    = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BEQ      = 4'd9;
    localparam state_t S_JAL      = 4'd10;
`ifdef MC_CTRL_JALR_EN
    localparam state_t S_JALRADR  = 4'd11;
`endif

    localparam logic [1:0] RESULT_ALUOUT = 2'b00;
    localparam logic [1:0] RESULT_DATA   = 2'b01;
    localparam logic [1:0] RESULT_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       instr_done;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // States that wait on the memory handshake and are covered by the watchdog.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/mc_ctrl_imm_dec.sv
// Immediate-format select decoded straight from the opcode.
// JALR (MC_CTRL_JALR_EN) uses the I format, which is the default arm.
module mc_imm_dec
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        case (op)
            OP_STORE: imm_src = IMM_S;
            OP_BEQ:   imm_src = IMM_B;
            OP_JAL:   imm_src = IMM_J;
            default:  imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM with memory-ready stalls and a stall watchdog.
// Define MC_CTRL_JALR_EN to accept JALR via the JALRADR state.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam int CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int EXP_INT = (TIMEOUT_CYCLES > 0) ? int'(TIMEOUT_CYCLES) - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(EXP_INT);

    state_t           state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             stalled, timeout, illegal;
    ctrl_t            ctrl;

    assign stalled = is_mem_state(state) && !mem_ready;
    assign timeout = (TIMEOUT_CYCLES != 0) && stalled && (wait_cnt == CNT_EXP);

    function automatic ctrl_t decode_ctrl(input state_t s, input logic ready);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.result_src = RESULT_ALURES;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.ir_write   = ready;
                c.pc_update  = ready;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = RESULT_DATA;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src    = 1'b1;
                c.mem_write  = 1'b1;
                c.instr_done = ready;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_RS2;
                c.alu_op     = ALUOP_SUB;
                c.branch     = 1'b1;
                c.instr_done = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_update = 1'b1;
            end
`ifdef MC_CTRL_JALR_EN
            S_JALRADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        next_state = state;
        illegal    = 1'b0;
        case (state)
            S_FETCH:    if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BEQ:            next_state = S_BEQ;
                    OP_JAL:            next_state = S_JAL;
`ifdef MC_CTRL_JALR_EN
                    OP_JALR:           next_state = S_JALRADR;
`endif
                    default: begin
                        next_state = S_FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   next_state = (Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
            S_EXECR,
            S_EXECI:    next_state = S_ALUWB;
            S_JAL:      next_state = S_ALUWB;
`ifdef MC_CTRL_JALR_EN
            S_JALRADR:  next_state = S_JAL;
`endif
            default:    next_state = S_FETCH;
        endcase
        if (timeout) next_state = S_FETCH;
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if ((next_state != state) || timeout)
                wait_cnt <= '0;
            else if (stalled && (wait_cnt != CNT_MAX))
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign ctrl = decode_ctrl(state, mem_ready);

    // Enables are forced low while reset is asserted and on a watchdog expiry.
    assign PCWrite     = rst_n & (ctrl.pc_update | (ctrl.branch & Zero));
    assign MemWrite    = rst_n & ctrl.mem_write & ~timeout;
    assign IRWrite     = rst_n & ctrl.ir_write;
    assign RegWrite    = rst_n & ctrl.reg_write;
    assign instr_done  = rst_n & ctrl.instr_done;
    assign illegal_op  = rst_n & illegal;
    assign mem_timeout = rst_n & timeout;
    assign AdrSrc      = ctrl.adr_src;
    assign ResultSrc   = ctrl.result_src;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;

    mc_imm_dec u_imm_dec (
        .op      (Op),
        .imm_src (ImmSrc)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (watchdog shortened to 4 cycles).
// Compile with MC_CTRL_JALR_EN to exercise the JALR path instead of the illegal-op path.
module tb_multicycle_ctrl;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] BAD  = 7'b0000000;

    // Field order: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA ALUSrcB ALUOp done illegal timeout
    localparam logic [15:0] E_RST    = {5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000};
    localparam logic [15:0] E_FETCH  = {5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000};
    localparam logic [15:0] E_FTMO   = {5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b001};
    localparam logic [15:0] E_DECODE = {5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000};
    localparam logic [15:0] E_ILL    = {5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b010};
    localparam logic [15:0] E_EXECR  = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000};
    localparam logic [15:0] E_EXECI  = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b10, 3'b000};
    localparam logic [15:0] E_ALUWB  = {5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100};
    localparam logic [15:0] E_MEMADR = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000};
    localparam logic [15:0] E_MEMRD  = {5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [15:0] E_MEMWB  = {5'b00001, 2'b01, 2'b00, 2'b00, 2'b00, 3'b100};
    localparam logic [15:0] E_MWSTL  = {5'b01100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [15:0] E_MWOK   = {5'b01100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100};
    localparam logic [15:0] E_MWTMO  = {5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001};
    localparam logic [15:0] E_BEQT   = {5'b10000, 2'b00, 2'b10, 2'b00, 2'b01, 3'b100};
    localparam logic [15:0] E_BEQN   = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b01, 3'b100};
    localparam logic [15:0] E_JAL    = {5'b10000, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] Op;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic       instr_done, illegal_op, mem_timeout;
    logic [15:0] obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Op          (Op),
        .Zero        (Zero),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .AdrSrc      (AdrSrc),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .ResultSrc   (ResultSrc),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .ImmSrc      (ImmSrc),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout)
    );

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal_op, mem_timeout};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp_v);
        checks++;
        assert (got === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp_v);
        end
    endtask

    // Called just after a falling edge: set mem_ready, check mid-cycle, move to the next falling edge.
    task automatic cyc(input string tag, input logic mr, input logic [15:0] exp_v);
        mem_ready = mr;
        #1;
        check(tag, obs, exp_v);
        @(negedge clk);
    endtask

    typedef struct { logic [6:0] op; logic [1:0] imm; } imm_vec_t;
    imm_vec_t imm_tbl[7] = '{
        '{LW, 2'b00}, '{SW, 2'b01}, '{RT, 2'b00}, '{IT, 2'b00},
        '{BEQ, 2'b10}, '{JAL, 2'b11}, '{JALR, 2'b00}
    };

    initial begin
        rst_n     = 1'b0;
        Op        = RT;
        Zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", obs, E_RST);
        for (int i = 0; i < 7; i++) begin
            Op = imm_tbl[i].op;
            #1;
            check($sformatf("imm_src_%b", imm_tbl[i].op), {14'd0, ImmSrc}, {14'd0, imm_tbl[i].imm});
        end
        Op = RT;
        @(negedge clk);
        rst_n = 1'b1;

        // R-type: 4 cycles, RegWrite and instr_done only in ALUWB.
        cyc("r_fetch", 1'b1, E_FETCH);
        cyc("r_decode", 1'b1, E_DECODE);
        cyc("r_execr", 1'b1, E_EXECR);
        cyc("r_aluwb", 1'b1, E_ALUWB);

        // LW with three stalled MEMREAD cycles; ready on the 4th (expiry) cycle wins.
        Op = LW;
        cyc("lw_fetch", 1'b1, E_FETCH);
        cyc("lw_decode", 1'b1, E_DECODE);
        cyc("lw_memadr", 1'b1, E_MEMADR);
        cyc("lw_memrd_stall1", 1'b0, E_MEMRD);
        cyc("lw_memrd_stall2", 1'b0, E_MEMRD);
        cyc("lw_memrd_stall3", 1'b0, E_MEMRD);
        cyc("lw_memrd_ready", 1'b1, E_MEMRD);
        cyc("lw_memwb", 1'b1, E_MEMWB);

        // BEQ taken then not taken.
        Op   = BEQ;
        Zero = 1'b1;
        cyc("beq_t_fetch", 1'b1, E_FETCH);
        cyc("beq_t_decode", 1'b1, E_DECODE);
        cyc("beq_taken", 1'b1, E_BEQT);
        Zero = 1'b0;
        cyc("beq_n_fetch", 1'b1, E_FETCH);
        cyc("beq_n_decode", 1'b1, E_DECODE);
        cyc("beq_not_taken", 1'b1, E_BEQN);

        // SW with memory never ready: watchdog fires on the 4th MEMWRITE cycle.
        Op = SW;
        cyc("sw_fetch", 1'b1, E_FETCH);
        cyc("sw_decode", 1'b1, E_DECODE);
        cyc("sw_memadr", 1'b1, E_MEMADR);
        cyc("sw_stall1", 1'b0, E_MWSTL);
        cyc("sw_stall2", 1'b0, E_MWSTL);
        cyc("sw_stall3", 1'b0, E_MWSTL);
        cyc("sw_timeout", 1'b0, E_MWTMO);

        // Back in FETCH: a stalled fetch also times out and stays in FETCH.
        cyc("f_stall1", 1'b0, E_RST);
        cyc("f_stall2", 1'b0, E_RST);
        cyc("f_stall3", 1'b0, E_RST);
        cyc("f_timeout", 1'b0, E_FTMO);

        // SW completing normally.
        cyc("sw2_fetch", 1'b1, E_FETCH);
        cyc("sw2_decode", 1'b1, E_DECODE);
        cyc("sw2_memadr", 1'b1, E_MEMADR);
        cyc("sw2_stall", 1'b0, E_MWSTL);
        cyc("sw2_done", 1'b1, E_MWOK);

        // JAL.
        Op = JAL;
        cyc("jal_fetch", 1'b1, E_FETCH);
        cyc("jal_decode", 1'b1, E_DECODE);
        cyc("jal_jal", 1'b1, E_JAL);
        cyc("jal_aluwb", 1'b1, E_ALUWB);

        // JALR: accepted only with the configuration macro.
        Op = JALR;
        cyc("jalr_fetch", 1'b1, E_FETCH);
`ifdef MC_CTRL_JALR_EN
        cyc("jalr_decode", 1'b1, E_DECODE);
        cyc("jalr_adr", 1'b1, E_MEMADR);
        cyc("jalr_jal", 1'b1, E_JAL);
        cyc("jalr_aluwb", 1'b1, E_ALUWB);
`else
        cyc("jalr_illegal", 1'b1, E_ILL);
`endif
        cyc("jalr_next_fetch", 1'b1, E_FETCH);

        // Unsupported opcode.
        Op = BAD;
        cyc("bad_decode", 1'b1, E_ILL);
        cyc("bad_next_fetch", 1'b1, E_FETCH);

        // Reset pulsed during EXECI: back to FETCH, no writeback.
        Op = IT;
        cyc("i_decode", 1'b1, E_DECODE);
        mem_ready = 1'b1;
        #1;
        check("i_execi", obs, E_EXECI);
        #1;
        rst_n = 1'b0;
        #1;
        check("i_reset_now", obs, E_RST);
        @(negedge clk);
        #1;
        check("i_reset_held", obs, E_RST);
        rst_n = 1'b1;
        cyc("i_after_reset_fetch", 1'b1, E_FETCH);
        cyc("i2_decode", 1'b1, E_DECODE);
        cyc("i2_execi", 1'b1, E_EXECI);
        cyc("i2_aluwb", 1'b1, E_ALUWB);
        cyc("i2_next_fetch", 1'b1, E_FETCH);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
